regfile_write_arbiter: RTL and testbench

Arbitrates the single register-file write port between two requesters: the pipeline writeback (WB) stage and a multi-cycle execution unit (MC, e.g. mult/div).
- WB has absolute priority and is never stalled.
- MC results wait in a small in-order queue until the port is free.
- The block also flags decode-stage RAW hazards against queued MC results.
- It sits between WB/MC and the register file. Its registered write outputs drive the register file's write enable, write address and write data, which the register file samples on the falling clock edge.

---
 rtl/regfile_write_arbiter.sv | 173 +++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between the writeback stage (WB)
//   and a multi-cycle execution unit (MC). WB always wins and is never stalled.
//   MC results that lose arbitration wait in a small in-order queue. The block
//   also flags decode RAW hazards against live queued MC results.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   wb_valid/wb_rd/wb_data WB write request (rd==0 is ignored)
//   mc_valid/mc_rd/mc_data MC result; mc_ready is the accept handshake
//   rs_addr, rt_addr       decode source registers; raw_stall flags a hazard
//   regWriteEn/writeR/writeData  registered write port; the register file
//                          samples it on the falling edge
//   q_count                occupied queue slots, live or dead

// One queue slot. A slot is loaded on push and goes dead when it is popped
// or when WB writes the same register. Unoccupied slots are always dead,
// so the hazard match can look at every slot without checking occupancy.
module regfile_wa_entry #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              setEn,
  input  logic              setLive,
  input  logic [ADDR_W-1:0] setRd,
  input  logic [DATA_W-1:0] setData,
  input  logic              clrEn,
  input  logic              killEn,
  input  logic [ADDR_W-1:0] killRd,
  input  logic [ADDR_W-1:0] rsAddr,
  input  logic [ADDR_W-1:0] rtAddr,
  output logic              live,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] data,
  output logic              hit
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live <= 1'b0;
      rd   <= '0;
      data <= '0;
    end else if (setEn) begin
      live <= setLive;
      rd   <= setRd;
      data <= setData;
    end else if (clrEn || (killEn && rd == killRd)) begin
      live <= 1'b0;
    end
  end

  assign hit = live && ((rsAddr != '0 && rd == rsAddr) ||
                        (rtAddr != '0 && rd == rtAddr));
endmodule

module regfile_write_arbiter #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_rd,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     mc_valid,
  input  logic [ADDR_W-1:0]        mc_rd,
  input  logic [DATA_W-1:0]        mc_data,
  output logic                     mc_ready,
  input  logic [ADDR_W-1:0]        rs_addr,
  input  logic [ADDR_W-1:0]        rt_addr,
  output logic                     raw_stall,
  output logic                     regWriteEn,
  output logic [ADDR_W-1:0]        writeR,
  output logic [DATA_W-1:0]        writeData,
  output logic [$clog2(DEPTH):0]   q_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] headPtr, tailPtr;

  logic [DEPTH-1:0]             entLive, entHit, entSet, entClr;
  logic [DEPTH-1:0][ADDR_W-1:0] entRd;
  logic [DEPTH-1:0][DATA_W-1:0] entData;

  logic wbReq, mcAcc, qEmpty, pop, bypass, push, pushLive;
  logic              headLive;
  logic [ADDR_W-1:0] headRd;
  logic [DATA_W-1:0] headData;

  assign mc_ready = (q_count < CW'(DEPTH));
  assign wbReq    = wb_valid && (wb_rd != '0);
  assign mcAcc    = mc_valid && mc_ready;
  assign qEmpty   = (q_count == '0);

  // Priority: WB, then queue head, then MC bypass. MC with rd==0 is
  // accepted but neither pushed nor bypassed.
  assign pop      = !wbReq && !qEmpty;
  assign bypass   = !wbReq && qEmpty && mcAcc && (mc_rd != '0);
  assign push     = mcAcc && (mc_rd != '0) && !bypass;
  // A result racing a WB write to the same register is already stale.
  assign pushLive = !(wbReq && mc_rd == wb_rd);

  assign headLive = entLive[headPtr];
  assign headRd   = entRd[headPtr];
  assign headData = entData[headPtr];

  assign raw_stall = |entHit;

  for (genvar g = 0; g < DEPTH; g++) begin : gEnt
    assign entSet[g] = push && (tailPtr == PW'(g));
    assign entClr[g] = pop  && (headPtr == PW'(g));

    regfile_wa_entry #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) uEnt (
      .clk     (clk),
      .rst     (rst),
      .setEn   (entSet[g]),
      .setLive (pushLive),
      .setRd   (mc_rd),
      .setData (mc_data),
      .clrEn   (entClr[g]),
      .killEn  (wbReq),
      .killRd  (wb_rd),
      .rsAddr  (rs_addr),
      .rtAddr  (rt_addr),
      .live    (entLive[g]),
      .rd      (entRd[g]),
      .data    (entData[g]),
      .hit     (entHit[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      headPtr <= '0;
      tailPtr <= '0;
      q_count <= '0;
    end else begin
      if (push) tailPtr <= tailPtr + PW'(1);
      if (pop)  headPtr <= headPtr + PW'(1);
      if (push && !pop)      q_count <= q_count + CW'(1);
      else if (pop && !push) q_count <= q_count - CW'(1);
    end
  end

  // Write port register. A dead head still consumes the pop slot but
  // leaves address/data untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWriteEn <= 1'b0;
      writeR     <= '0;
      writeData  <= '0;
    end else if (wbReq) begin
      regWriteEn <= 1'b1;
      writeR     <= wb_rd;
      writeData  <= wb_data;
    end else if (pop) begin
      regWriteEn <= headLive;
      if (headLive) begin
        writeR    <= headRd;
        writeData <= headData;
      end
    end else if (bypass) begin
      regWriteEn <= 1'b1;
      writeR     <= mc_rd;
      writeData  <= mc_data;
    end else begin
      regWriteEn <= 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, mc_valid, mc_ready, raw_stall, regWriteEn;
  logic [4:0]  wb_rd, mc_rd, rs_addr, rt_addr, writeR;
  logic [31:0] wb_data, mc_data, writeData;
  logic [1:0]  q_count;

  regfile_write_arbiter #(.DEPTH(2), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data), .mc_ready(mc_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .raw_stall(raw_stall),
    .regWriteEn(regWriteEn), .writeR(writeR), .writeData(writeData),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] data; } wr_t;
  wr_t expQ[$];
  logic [31:0] rf [32];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expWr(input logic [4:0] rd, input logic [31:0] data);
    wr_t e;
    e.rd = rd;
    e.data = data;
    expQ.push_back(e);
  endtask

  // Monitor: the register file samples on the falling edge.
  always @(negedge clk) begin
    if (!rst && regWriteEn) begin
      if (expQ.size() == 0) begin
        chk("unexpected_write_addr", {59'd0, writeR}, 64'hFFFF);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        chk("wr_addr", {59'd0, writeR}, {59'd0, e.rd});
        chk("wr_data", {32'd0, writeData}, {32'd0, e.data});
      end
      rf[writeR] = writeData;
    end
  end

  task automatic setWb(input logic v, input logic [4:0] rd, input logic [31:0] d);
    wb_valid = v; wb_rd = rd; wb_data = d;
  endtask
  task automatic setMc(input logic v, input logic [4:0] rd, input logic [31:0] d);
    mc_valid = v; mc_rd = rd; mc_data = d;
  endtask
  task automatic idle();
    setWb(1'b0, 5'd0, 32'd0);
    setMc(1'b0, 5'd0, 32'd0);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int k;
    int wbn;
    logic wbPlan [16];
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rst = 1'b1; rs_addr = '0; rt_addr = '0;
    idle();
    cyc(); cyc();
    chk("reset_wen",   {63'd0, regWriteEn}, 64'd0);
    chk("reset_addr",  {59'd0, writeR}, 64'd0);
    chk("reset_data",  {32'd0, writeData}, 64'd0);
    chk("reset_qcount",{62'd0, q_count}, 64'd0);
    rst = 1'b0;
    cyc();
    chk("post_reset_ready", {63'd0, mc_ready}, 64'd1);

    // Bypass on an idle port
    setMc(1'b1, 5'd7, 32'h1234); expWr(5'd7, 32'h1234);
    cyc(); idle();
    chk("bypass_wen",    {63'd0, regWriteEn}, 64'd1);
    chk("bypass_qcount", {62'd0, q_count}, 64'd0);
    cyc();
    chk("bypass_done_wen", {63'd0, regWriteEn}, 64'd0);

    // WB priority with MC queueing
    expWr(5'd3, 32'h33); expWr(5'd4, 32'h44); expWr(5'd5, 32'h55);
    expWr(5'd6, 32'h66); expWr(5'd8, 32'hA);  expWr(5'd9, 32'hB);
    setWb(1'b1, 5'd3, 32'h33); setMc(1'b1, 5'd8, 32'hA); rs_addr = 5'd8;
    cyc();
    chk("prio_qcount1", {62'd0, q_count}, 64'd1);
    setWb(1'b1, 5'd4, 32'h44); setMc(1'b1, 5'd9, 32'hB);
    cyc(); setMc(1'b0, 5'd0, 32'd0);
    chk("prio_qcount2", {62'd0, q_count}, 64'd2);
    chk("prio_full_ready", {63'd0, mc_ready}, 64'd0);
    chk("prio_raw_r8", {63'd0, raw_stall}, 64'd1);
    setWb(1'b1, 5'd5, 32'h55);
    cyc();
    chk("prio_raw_r8_hold", {63'd0, raw_stall}, 64'd1);
    setWb(1'b1, 5'd6, 32'h66);
    cyc(); idle();
    cyc();
    chk("prio_raw_r8_popped", {63'd0, raw_stall}, 64'd0);
    chk("prio_qcount_pop1", {62'd0, q_count}, 64'd1);
    cyc();
    chk("prio_qcount_pop2", {62'd0, q_count}, 64'd0);
    rs_addr = '0;

    // Supersede a queued entry
    expWr(5'd11, 32'h11); expWr(5'd10, 32'h99);
    setWb(1'b1, 5'd11, 32'h11); setMc(1'b1, 5'd10, 32'h55); rs_addr = 5'd10;
    cyc(); setMc(1'b0, 5'd0, 32'd0);
    chk("sup_raw_live", {63'd0, raw_stall}, 64'd1);
    setWb(1'b1, 5'd10, 32'h99);
    cyc(); idle();
    chk("sup_raw_dead", {63'd0, raw_stall}, 64'd0);
    chk("sup_qcount",   {62'd0, q_count}, 64'd1);
    cyc();
    chk("sup_dead_pop_wen", {63'd0, regWriteEn}, 64'd0);
    chk("sup_qcount_empty", {62'd0, q_count}, 64'd0);
    rs_addr = '0;

    // MC result racing WB to the same register is pushed dead
    expWr(5'd12, 32'hC1);
    setWb(1'b1, 5'd12, 32'hC1); setMc(1'b1, 5'd12, 32'hC2); rt_addr = 5'd12;
    cyc(); idle();
    chk("race_qcount", {62'd0, q_count}, 64'd1);
    chk("race_raw",    {63'd0, raw_stall}, 64'd0);
    cyc();
    chk("race_dead_pop_wen", {63'd0, regWriteEn}, 64'd0);
    chk("race_qcount_empty", {62'd0, q_count}, 64'd0);
    rt_addr = '0;

    // Register 0 is never written
    setWb(1'b1, 5'd0, 32'hDEAD);
    cyc(); idle();
    chk("r0_wb_wen", {63'd0, regWriteEn}, 64'd0);
    setMc(1'b1, 5'd0, 32'hBEEF);
    cyc(); idle();
    chk("r0_mc_qcount", {62'd0, q_count}, 64'd0);
    chk("r0_mc_wen",    {63'd0, regWriteEn}, 64'd0);
    expWr(5'd19, 32'h19);
    setWb(1'b1, 5'd19, 32'h19); setMc(1'b1, 5'd0, 32'hBEEF);
    cyc(); idle();
    chk("r0_mc_busy_qcount", {62'd0, q_count}, 64'd0);
    cyc();

    // Pointer wrap: 6 MC results under bursty WB pressure
    for (int i = 0; i < 16; i++) wbPlan[i] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wbPlan[i] = 1'b1; wbPlan[i+5] = 1'b1; wbPlan[i+10] = 1'b1;
    end
    expWr(5'd20, 32'h2000); expWr(5'd21, 32'h2001); expWr(5'd22, 32'h2002);
    expWr(5'd13, 32'h1000); expWr(5'd14, 32'h1001);
    expWr(5'd23, 32'h2003); expWr(5'd24, 32'h2004); expWr(5'd25, 32'h2005);
    expWr(5'd15, 32'h1002); expWr(5'd16, 32'h1003);
    expWr(5'd26, 32'h2006); expWr(5'd27, 32'h2007); expWr(5'd28, 32'h2008);
    expWr(5'd17, 32'h1004); expWr(5'd18, 32'h1005);
    k = 0; wbn = 0;
    for (int i = 0; i < 16; i++) begin
      if (wbPlan[i]) begin
        setWb(1'b1, 5'(20 + wbn), 32'h2000 + 32'(wbn));
        wbn++;
      end else begin
        setWb(1'b0, 5'd0, 32'd0);
      end
      if (k < 6) setMc(1'b1, 5'(13 + k), 32'h1000 + 32'(k));
      else       setMc(1'b0, 5'd0, 32'd0);
      acc = mc_valid && mc_ready;
      cyc();
      if (acc) k++;
      chk("wrap_qcount_le2", {63'd0, (q_count <= 2'd2)}, 64'd1);
    end
    idle();
    chk("wrap_accepted", 64'(k), 64'd6);
    chk("wrap_qcount_end", {62'd0, q_count}, 64'd0);

    // Reset mid-cycle with two entries queued
    expWr(5'd29, 32'hA1);
    setWb(1'b1, 5'd29, 32'hA1); setMc(1'b1, 5'd30, 32'hC0); rs_addr = 5'd30;
    cyc();
    setWb(1'b1, 5'd31, 32'hA2); setMc(1'b1, 5'd14, 32'hC1);
    cyc(); idle();
    chk("rst_pre_qcount", {62'd0, q_count}, 64'd2);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_wen",    {63'd0, regWriteEn}, 64'd0);
    chk("rst_mid_addr",   {59'd0, writeR}, 64'd0);
    chk("rst_mid_data",   {32'd0, writeData}, 64'd0);
    chk("rst_mid_qcount", {62'd0, q_count}, 64'd0);
    chk("rst_mid_raw",    {63'd0, raw_stall}, 64'd0);
    cyc(); cyc();
    rst = 1'b0; rs_addr = '0;
    for (int i = 0; i < 4; i++) cyc();
    chk("rst_after_qcount", {62'd0, q_count}, 64'd0);

    chk("sb_drained", 64'(expQ.size()), 64'd0);
    chk("r10_final", {32'd0, rf[10]}, 64'h99);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
